// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//   Shared definitions for the instruction cache controller: FSM state
//   encodings and small constants used by icache_ctrl and icache_array.
// -----------------------------------------------------------------------------
package icache_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_FILL = 2'd1,
    ICACHE_RESP = 2'd2
  } icache_state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // log2 of the bytes in one instruction word.
  localparam int WORD_BYTES_LG = 2;

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
//   Valid / tag / data storage for the direct-mapped instruction cache.
//   One synchronous word write port, one combinational read port that
//   returns the valid bit, the tag and one word of the indexed line.
//
// Ports
//   clk, rst        clock, synchronous active-high reset (clears valid bits)
//   we_i            write one data word at [widx_i][wword_i]
//   line_done_i     with we_i: this is the last word, install tag and valid
//   wtag_i          tag written when line_done_i
//   ridx_i, rword_i read address (line index, word in line)
//   rvalid_o        valid bit of line ridx_i
//   rtag_o          tag of line ridx_i
//   rdata_o         word rword_i of line ridx_i
// -----------------------------------------------------------------------------
module icache_array #(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4,
  parameter int WO_W       = 2,
  parameter int TAG_W      = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic                  line_done_i,
  input  logic [INDEX_BITS-1:0] widx_i,
  input  logic [WO_W-1:0]       wword_i,
  input  logic [31:0]           wdata_i,
  input  logic [TAG_W-1:0]      wtag_i,
  input  logic [INDEX_BITS-1:0] ridx_i,
  input  logic [WO_W-1:0]       rword_i,
  output logic                  rvalid_o,
  output logic [TAG_W-1:0]      rtag_o,
  output logic [31:0]           rdata_o
);

  localparam int NLINES = 2 ** INDEX_BITS;

  logic [31:0]      data_q  [NLINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q   [NLINES];
  logic [NLINES-1:0] valid_q;

  // Data and tags need no reset: nothing is read without a valid bit.
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[widx_i][wword_i] <= wdata_i;
      if (line_done_i) tag_q[widx_i] <= wtag_i;
    end
  end

  // A line becomes valid only together with its final word, so a fill cut
  // short by reset leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i && line_done_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i][rword_i];

endmodule

// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
//   Direct-mapped instruction cache and line-fill sequencer between the fetch
//   unit and the fetch port of the memory controller. Hits answer in one
//   cycle; a miss fetches LINE_WORDS words one at a time, installs the line
//   and then returns the requested word. A ROB rollback cancels the pending
//   response, but an in-flight fill always completes and is installed.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; low freezes all state
//   if_req, if_pc     fetch request (held until if_ready) and its address
//   if_ready, if_ins  one-cycle response pulse and instruction
//   rollback          ROB flush
//   mem_pc            word address of the current line-fill request
//   mem_miss_sgn      word request to memory controller
//   mem_finish        one-cycle word-done pulse, mem_ins valid with it
//   hit_cnt, miss_cnt performance counters (only with ICACHE_STATS_EN)
//
// Build option
//   ICACHE_STATS_EN   adds the hit/miss counters and their output ports.
// -----------------------------------------------------------------------------
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic [31:0] if_ins,
  input  logic        rollback,
  output logic [31:0] mem_pc,
  output logic        mem_miss_sgn,
  input  logic        mem_finish,
  input  logic [31:0] mem_ins
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WO_W  = $clog2(LINE_WORDS);
  localparam int OFF_W = WO_W + WORD_BYTES_LG;
  localparam int TAG_W = 32 - OFF_W - INDEX_BITS;
  localparam logic [WO_W-1:0] LAST_WORD = WO_W'(LINE_WORDS - 1);

  // ---------------------------------------------------------------------------
  // Address split of the incoming fetch PC
  // ---------------------------------------------------------------------------
  logic [WO_W-1:0]       pc_word;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic                  unused_pc_byte;

  assign pc_word        = if_pc[OFF_W-1:WORD_BYTES_LG];
  assign pc_idx         = if_pc[OFF_W+INDEX_BITS-1:OFF_W];
  assign pc_tag         = if_pc[31:OFF_W+INDEX_BITS];
  assign unused_pc_byte = ^if_pc[WORD_BYTES_LG-1:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  icache_state_e         state_q;
  logic [TAG_W-1:0]      fill_tag_q;
  logic [INDEX_BITS-1:0] fill_idx_q;
  logic [WO_W-1:0]       off_q;
  logic [WO_W-1:0]       wcnt_q;
  logic [WO_W-1:0]       wcnt_d;
  logic                  drop_q;
  logic                  if_ready_q;
  logic [31:0]           if_ins_q;
  logic [31:0]           mem_pc_q;
  logic [31:0]           mem_pc_d;
`ifdef ICACHE_STATS_EN
  logic [31:0]           hit_cnt_q;
  logic [31:0]           miss_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic                  arr_we;
  logic                  arr_line_done;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [WO_W-1:0]       rd_word;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [31:0]           rd_data;

  // In IDLE the read port looks up the fetch PC; during a fill it points at
  // the requested word of the line being filled, for the final response.
  assign rd_idx  = (state_q == ICACHE_IDLE) ? pc_idx  : fill_idx_q;
  assign rd_word = (state_q == ICACHE_IDLE) ? pc_word : off_q;

  assign arr_we        = rdy && !rst && (state_q == ICACHE_FILL) && mem_finish;
  assign arr_line_done = (wcnt_q == LAST_WORD);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .LINE_WORDS (LINE_WORDS),
    .WO_W       (WO_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .we_i        (arr_we),
    .line_done_i (arr_line_done),
    .widx_i      (fill_idx_q),
    .wword_i     (wcnt_q),
    .wdata_i     (mem_ins),
    .wtag_i      (fill_tag_q),
    .ridx_i      (rd_idx),
    .rword_i     (rd_word),
    .rvalid_o    (rd_valid),
    .rtag_o      (rd_tag),
    .rdata_o     (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic        accept;
  logic        hit;
  logic        resp_drop;
  logic [31:0] resp_word;

  // A request still held high in the response cycle must not be re-accepted.
  assign accept = if_req && !rollback && !if_ready_q;
  assign hit    = rd_valid && (rd_tag == pc_tag);

  assign wcnt_d   = wcnt_q + 1'b1;
  assign mem_pc_d = {fill_tag_q, fill_idx_q, wcnt_d, {WORD_BYTES_LG{1'b0}}};

  // Rollback in the last fill cycle still counts against the response.
  assign resp_drop = drop_q || rollback;

  // If the requested word is the one arriving now it is not in the array yet.
  assign resp_word = (off_q == wcnt_q) ? mem_ins : rd_data;

  // The response register is loaded on the edge that retires the last word,
  // so if_ready is high during RESP: one cycle after the final mem_finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ICACHE_IDLE;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      off_q      <= '0;
      wcnt_q     <= '0;
      drop_q     <= FALSE;
      if_ready_q <= FALSE;
      if_ins_q   <= '0;
      mem_pc_q   <= '0;
`ifdef ICACHE_STATS_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else if (rdy) begin
      if_ready_q <= FALSE;
      case (state_q)
        ICACHE_IDLE: begin
          if (accept) begin
            if (hit) begin
              if_ready_q <= TRUE;
              if_ins_q   <= rd_data;
`ifdef ICACHE_STATS_EN
              hit_cnt_q  <= hit_cnt_q + 32'd1;
`endif
            end else begin
              fill_tag_q <= pc_tag;
              fill_idx_q <= pc_idx;
              off_q      <= pc_word;
              wcnt_q     <= '0;
              drop_q     <= FALSE;
              mem_pc_q   <= {pc_tag, pc_idx, {OFF_W{1'b0}}};
              state_q    <= ICACHE_FILL;
`ifdef ICACHE_STATS_EN
              miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
            end
          end
        end
        ICACHE_FILL: begin
          if (rollback) drop_q <= TRUE;
          if (mem_finish) begin
            wcnt_q   <= wcnt_d;
            mem_pc_q <= mem_pc_d;
            if (arr_line_done) begin
              state_q <= ICACHE_RESP;
              if (!resp_drop) begin
                if_ready_q <= TRUE;
                if_ins_q   <= resp_word;
              end
            end
          end
        end
        ICACHE_RESP: begin
          drop_q  <= FALSE;
          state_q <= ICACHE_IDLE;
        end
        default: state_q <= ICACHE_IDLE;
      endcase
    end
  end

  // Dropped low in the finish cycle so the controller never re-issues the
  // address it has just completed.
  assign mem_miss_sgn = (state_q == ICACHE_FILL) && !mem_finish;

  assign if_ready = if_ready_q;
  assign if_ins   = if_ins_q;
  assign mem_pc   = mem_pc_q;
`ifdef ICACHE_STATS_EN
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache and line-fill sequencer between the instruction-fetch unit and the fetch port of the byte-serial memory controller. It serves fetch hits in one cycle. On a miss it sequences LINE_WORDS single-word fetch requests through the memory controller, installs the line, then returns the requested word. It also owns cancellation on ROB rollback.

## Interface
Parameters:
- INDEX_BITS, 4, number of lines = 2^INDEX_BITS.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global ready; low freezes all state and outputs.
- if_req  in  1  fetch request. Held high by IF until if_ready.
- if_pc  in  32  fetch address. Stable while if_req is high; bits [1:0] ignored.
- if_ready  out  1  one-cycle pulse; if_ins is valid.
- if_ins  out  32  fetched instruction.
- rollback  in  1  ROB flush; cancels the pending fetch response.
- mem_pc  out  32  word address to memory controller.
- mem_miss_sgn  out  1  word-fetch request to memory controller.
- mem_finish  in  1  one-cycle word-done pulse from memory controller.
- mem_ins  in  32  fetched word; valid with mem_finish.
- hit_cnt, miss_cnt  out  32  performance counters; present only with ICACHE_STATS_EN.

## Operation
- Address split: offset = log2(LINE_WORDS)+2 bits; index = next INDEX_BITS bits; tag = the remaining upper bits.
- FSM states: IDLE, FILL, RESP.
- IDLE:
  - Accepts if_req when rollback=0 and if_ready=0 in that cycle. This prevents a duplicate accept of a request still held high.
  - On a hit, registers the word and pulses if_ready next cycle. State stays IDLE.
  - On a miss, latches line base = {tag, index, 0} and the word offset, clears word counter wcnt, and goes to FILL.
- FILL:
  - mem_pc = base + 4·wcnt, registered.
  - mem_miss_sgn = (state==FILL) && !mem_finish, combinational. It must be low in every cycle mem_finish is high so the controller does not refetch the old address.
  - On mem_finish: write mem_ins into data[index][wcnt] and increment wcnt.
  - On the last word: write the tag, set valid, go to RESP.
  - mem_finish outside FILL is ignored.
- RESP: if drop=0, pulse if_ready with data[index][offset]. Clear drop and go to IDLE.
- Rollback:
  - In IDLE, suppresses a hit response due next cycle.
  - In FILL or RESP, sets drop. The fill always completes, because the memory controller cannot abort, and the line is installed.
  - An if_req arriving during a fill waits until IDLE.
- Reset: all valid bits cleared, state IDLE, wcnt 0, drop 0. A reset mid-fill abandons the line, which stays invalid.

## Timing
- Reset values: if_ready 0, if_ins 0, mem_pc 0, mem_miss_sgn 0, counters 0.
- Hit latency: accept at edge k → if_ready high during cycle k+1.
- Miss latency: if_ready exactly one cycle after the cycle holding the last mem_finish. Total time otherwise depends on the controller (store/load have priority there).
- After each mem_finish, mem_miss_sgn re-asserts the next cycle with the next address.
- rdy=0: no state change. mem_miss_sgn still follows its combinational equation on frozen state.
- rollback and if_req in the same cycle: rollback wins; request not accepted.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_cnt increments on each accepted hit; miss_cnt on each accepted miss.
  - 32-bit, wrap on overflow; not cleared by rollback.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- defines.v (shared): FSM encodings ICACHE_IDLE, ICACHE_FILL, ICACHE_RESP; existing TRUE/FALSE.
- Sub-module icache_array: valid, tag and data storage. It has a synchronous word write and a combinational index read of tag, valid and word.
- The FSM, address split and counters live in icache_ctrl.

## Test plan
- Use the defaults INDEX_BITS=4, LINE_WORDS=4.
- Cold miss: if_req pc=0x0 → mem_pc 0x0, 0x4, 0x8, 0xC in order; if_ready one cycle after 4th mem_finish with word@0x0; mem_miss_sgn low in every finish cycle.
- Hit: after the above, if_req pc=0x8 → if_ready next cycle with word@0x8; no mem_miss_sgn.
- Conflict: pc=0x100 (index 0, new tag) → refill; then pc=0x0 → miss again (4 requests).
- Rollback mid-fill: miss at 0x200, rollback after 2nd mem_finish → 4 words fetched, no if_ready; then if_req 0x204 → hit, 1-cycle response.
- Stall: rdy=0 for 3 cycles mid-fill → mem_pc, wcnt, state unchanged; fill resumes correctly. Reset mid-fill → later pc in that line misses.
- Stats (ICACHE_STATS_EN): sequence cold miss 0x0, hit 0x8, miss 0x100 → hit_cnt=1, miss_cnt=2.
